// File: rtl/ac97_pkg.sv
// Shared AC97 frame geometry, slot/tag bit positions, link state and command types.
// Also holds the codec vendor-ID constants used by the optional register file (AC97_CODEC_REGFILE_EN).
package ac97_pkg;

    localparam int FRAME_BITS = 256;
    localparam int SLOT0_W    = 16;
    localparam int SLOT_W     = 20;

    // Tag (slot0) bit indices within the 16-bit tag
    localparam int TAG_VALID = 15;
    localparam int TAG_SLOT1 = 14;
    localparam int TAG_SLOT2 = 13;

    // Slot LSB positions within the 256-bit frame
    localparam int TAG_LSB   = FRAME_BITS - SLOT0_W;
    localparam int SLOT1_LSB = TAG_LSB - SLOT_W;
    localparam int SLOT2_LSB = SLOT1_LSB - SLOT_W;

    localparam int FRM_VALID_BIT = TAG_LSB + TAG_VALID;
    localparam int FRM_SLOT1_BIT = TAG_LSB + TAG_SLOT1;
    localparam int FRM_SLOT2_BIT = TAG_LSB + TAG_SLOT2;
    localparam int S1_RW_BIT     = SLOT1_LSB + 19;
    localparam int S1_ADDR_LSB   = SLOT1_LSB + 12;
    localparam int S2_DATA_LSB   = SLOT2_LSB + 4;

    localparam logic [6:0]  VID1_ADDR = 7'h7C;
    localparam logic [6:0]  VID2_ADDR = 7'h7E;
    localparam logic [15:0] VID1_DATA = 16'h4144;
    localparam logic [15:0] VID2_DATA = 16'h5370;

    typedef enum logic {HUNT, FRAME} link_state_e;

    typedef struct packed {
        logic        write;
        logic [6:0]  addr;
        logic [15:0] data;
    } ac97_cmd_t;

    function automatic logic is_id_reg(input logic [6:0] a);
        return (a == VID1_ADDR) || (a == VID2_ADDR);
    endfunction

endpackage

// File: rtl/ac97_codec_regfile.sv
// 64x16 codec register file at even addresses; vendor-ID registers are read-only constants.
// Instantiated by ac97_codec_link only when AC97_CODEC_REGFILE_EN is defined.
module ac97_codec_regfile
    import ac97_pkg::*;
(
    input  logic        SYSCLK,
    input  logic        SYSTEM_RESET,
    input  logic        we,
    input  logic [6:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [6:0]  raddr,
    output logic [15:0] rdata
);

    logic [63:0][15:0] mem;

    always_ff @(posedge SYSCLK or negedge SYSTEM_RESET) begin
        if (!SYSTEM_RESET) begin
            mem <= '0;
        end else if (we && !is_id_reg(waddr)) begin
            mem[waddr[6:1]] <= wdata;
        end
    end

    always_comb begin
        rdata = mem[raddr[6:1]];
        if (raddr == VID1_ADDR) rdata = VID1_DATA;
        if (raddr == VID2_ADDR) rdata = VID2_DATA;
    end

endmodule

// File: rtl/ac97_codec_link.sv
// Codec-side AC-link endpoint: SYNC framing, 256-bit RX/TX shifting and slot1/slot2 command decode.
// Define AC97_CODEC_REGFILE_EN to add the internal register file and read-response insertion.
module ac97_codec_link #(
    parameter int FRAME_BITS   = 256,
    parameter int SYNC_HI_BITS = 16
) (
    input  logic                  BIT_CLK,
    input  logic                  RESET,
    input  logic                  SYNC,
    input  logic                  SDATA_OUT,
    output logic                  SDATA_IN,
    input  logic [FRAME_BITS-1:0] FRAME_IN,
    output logic                  FRAME_LOAD,
    output logic [FRAME_BITS-1:0] FRAME_OUT,
    output logic                  FRAME_VALID,
    output logic                  CMD_VALID,
    output logic                  CMD_WRITE,
    output logic [6:0]            CMD_ADDR,
    output logic [15:0]           CMD_DATA,
    output logic                  SYNC_ERR
);
    import ac97_pkg::*;

    link_state_e           state_q, state_d;
    logic [7:0]            cnt_q;
    logic                  sync_q;
    logic [FRAME_BITS-1:0] rx_sr, tx_sr, rx_full, tx_load;
    ac97_cmd_t             cmd_q, cmd_d;

    logic in_frame, last, rise, fall, start, restart_mid;
    logic drop_err, long_err, last_err, sync_err;
    logic cmd_ok, cmd_fire;

    // rx_full is the frame as it stands once this edge's bit is shifted in
    assign rx_full  = {rx_sr[FRAME_BITS-2:0], SDATA_OUT};
    assign SDATA_IN = tx_sr[FRAME_BITS-1];

    always_comb begin
        in_frame    = (state_q == FRAME);
        last        = in_frame && (cnt_q == 8'(FRAME_BITS-1));
        rise        = SYNC && !sync_q;
        fall        = !SYNC && sync_q;
        restart_mid = in_frame && !last && rise && (cnt_q >= 8'(SYNC_HI_BITS-1));
        drop_err    = in_frame && fall && (cnt_q < 8'(SYNC_HI_BITS-1));
        long_err    = in_frame && SYNC && sync_q && (cnt_q == 8'(SYNC_HI_BITS-1));
        last_err    = last && !SYNC;
        sync_err    = drop_err || long_err || restart_mid || last_err;
        start       = (!in_frame && rise) || restart_mid || (last && SYNC);
    end

    always_comb begin
        state_d = state_q;
        if (start)     state_d = FRAME;
        else if (last) state_d = HUNT;
    end

    always_ff @(posedge BIT_CLK or negedge RESET) begin
        if (!RESET) state_q <= HUNT;
        else        state_q <= state_d;
    end

    always_comb begin
        cmd_d.write = !rx_full[S1_RW_BIT];
        cmd_d.addr  = rx_full[S1_ADDR_LSB +: 7];
        cmd_d.data  = cmd_d.write ? rx_full[S2_DATA_LSB +: 16] : 16'h0;
        cmd_ok      = rx_full[FRM_VALID_BIT] && rx_full[FRM_SLOT1_BIT] &&
                      (!cmd_d.write || rx_full[FRM_SLOT2_BIT]);
        cmd_fire    = last && cmd_ok;
    end

`ifdef AC97_CODEC_REGFILE_EN
    logic [15:0] rf_rdata, rd_data_q;
    logic [6:0]  rd_addr_q;
    logic        rd_pend_q, rd_now;

    assign rd_now = cmd_fire && !cmd_d.write;

    ac97_codec_regfile u_regfile (
        .SYSCLK       (BIT_CLK),
        .SYSTEM_RESET (RESET),
        .we           (cmd_fire && cmd_d.write),
        .waddr        (cmd_d.addr),
        .wdata        (cmd_d.data),
        .raddr        (cmd_d.addr),
        .rdata        (rf_rdata)
    );

    // A read decoded on a back-to-back boundary is answered in the frame starting
    // at that same edge; otherwise it waits for the next start edge.
    always_ff @(posedge BIT_CLK or negedge RESET) begin
        if (!RESET) begin
            rd_pend_q <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else if (start) begin
            rd_pend_q <= 1'b0;
        end else if (rd_now) begin
            rd_pend_q <= 1'b1;
            rd_addr_q <= cmd_d.addr;
            rd_data_q <= rf_rdata;
        end
    end

    always_comb begin
        tx_load = FRAME_IN;
        if (rd_now || rd_pend_q) begin
            tx_load[FRM_SLOT1_BIT]        = 1'b1;
            tx_load[FRM_SLOT2_BIT]        = 1'b1;
            tx_load[SLOT1_LSB +: SLOT_W]  = {1'b0, (rd_now ? cmd_d.addr : rd_addr_q), 12'h0};
            tx_load[SLOT2_LSB +: SLOT_W]  = {(rd_now ? rf_rdata : rd_data_q), 4'h0};
        end
    end
`else
    assign tx_load = FRAME_IN;
`endif

    always_ff @(posedge BIT_CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_q       <= '0;
            sync_q      <= 1'b0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            FRAME_OUT   <= '0;
            FRAME_VALID <= 1'b0;
            FRAME_LOAD  <= 1'b0;
            SYNC_ERR    <= 1'b0;
            CMD_VALID   <= 1'b0;
            cmd_q       <= '0;
        end else begin
            sync_q      <= SYNC;
            FRAME_VALID <= last;
            FRAME_LOAD  <= start;
            SYNC_ERR    <= sync_err;
            CMD_VALID   <= cmd_fire;
            if (in_frame) rx_sr <= rx_full;
            if (start)         cnt_q <= '0;
            else if (in_frame) cnt_q <= cnt_q + 8'd1;
            tx_sr <= start ? tx_load : {tx_sr[FRAME_BITS-2:0], 1'b0};
            if (last)     FRAME_OUT <= rx_full;
            if (cmd_fire) cmd_q     <= cmd_d;
        end
    end

    assign CMD_WRITE = cmd_q.write;
    assign CMD_ADDR  = cmd_q.addr;
    assign CMD_DATA  = cmd_q.data;

endmodule

// File: tb/tb_ac97_codec_link.sv
// Directed bench for ac97_codec_link: framing, TX serialisation, SYNC violations, reset and commands.
module tb_ac97_codec_link;

    logic         BIT_CLK = 1'b0;
    logic         RESET;
    logic         SYNC;
    logic         SDATA_OUT;
    logic         SDATA_IN;
    logic [255:0] FRAME_IN;
    logic         FRAME_LOAD;
    logic [255:0] FRAME_OUT;
    logic         FRAME_VALID;
    logic         CMD_VALID;
    logic         CMD_WRITE;
    logic [6:0]   CMD_ADDR;
    logic [15:0]  CMD_DATA;
    logic         SYNC_ERR;

    ac97_codec_link dut (
        .BIT_CLK     (BIT_CLK),
        .RESET       (RESET),
        .SYNC        (SYNC),
        .SDATA_OUT   (SDATA_OUT),
        .SDATA_IN    (SDATA_IN),
        .FRAME_IN    (FRAME_IN),
        .FRAME_LOAD  (FRAME_LOAD),
        .FRAME_OUT   (FRAME_OUT),
        .FRAME_VALID (FRAME_VALID),
        .CMD_VALID   (CMD_VALID),
        .CMD_WRITE   (CMD_WRITE),
        .CMD_ADDR    (CMD_ADDR),
        .CMD_DATA    (CMD_DATA),
        .SYNC_ERR    (SYNC_ERR)
    );

    always #5 BIT_CLK = ~BIT_CLK;

    int n_vec = 0, n_err = 0;
    int fv_cnt, err_cnt, load_cnt, cmd_cnt, err_idx;
    logic [255:0] last_fo, cap;
    logic         c_wr, pend_bit;
    logic [6:0]   c_addr;
    logic [15:0]  c_data;

    localparam logic [255:0] FR_A  = {16'hE000, 20'h02000, 20'h12340, {10{20'hABCDE}}};
    localparam logic [255:0] FR_B  = {16'h8000, {12{20'h5A3C1}}};
    localparam logic [255:0] FR_W  = {16'hE000, 20'h02000, 20'hBEEF0, 200'h0};
    localparam logic [255:0] FR_RD = {16'hC000, 20'h82000, 220'h0};

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic clr();
        fv_cnt = 0; err_cnt = 0; load_cnt = 0; cmd_cnt = 0; err_idx = -1;
    endtask

    // One BIT_CLK edge: drive on the falling edge, observe 1 ns after the rising edge
    task automatic step(input logic s, input logic d, input int idx);
        @(negedge BIT_CLK);
        SYNC = s; SDATA_OUT = d;
        @(posedge BIT_CLK); #1;
        if (FRAME_VALID) begin fv_cnt++; last_fo = FRAME_OUT; end
        if (SYNC_ERR)    begin err_cnt++; err_idx = idx; end
        if (FRAME_LOAD)  load_cnt++;
        if (CMD_VALID)   begin cmd_cnt++; c_wr = CMD_WRITE; c_addr = CMD_ADDR; c_data = CMD_DATA; end
        if (idx >= 0 && idx < 256) cap[255-idx] = SDATA_IN;
    endtask

    // Edges S..S+n-1; bit 0 of a full frame is driven on the next frame's start edge
    task automatic drive_frame(input logic [255:0] f, input int hi, input int n);
        for (int i = 0; i < n; i++)
            step(i < hi, (i == 0) ? pend_bit : f[256-i], i);
        if (n == 256) pend_bit = f[0];
    endtask

    logic [255:0] exp_tx;

    initial begin
        RESET = 1'b0; SYNC = 1'b0; SDATA_OUT = 1'b0; pend_bit = 1'b0;
        FRAME_IN = {32{8'hA5}};
        cap = '0; last_fo = '0; c_wr = 1'b0; c_addr = '0; c_data = '0;
        clr();
        repeat (3) @(posedge BIT_CLK);
        #1;
        chk("rst_frame_out", FRAME_OUT, 256'h0);
        chk("rst_outs", 256'({SDATA_IN, FRAME_VALID, FRAME_LOAD, CMD_VALID, SYNC_ERR, CMD_WRITE}), 256'h0);
        chk("rst_cmd", 256'({CMD_ADDR, CMD_DATA}), 256'h0);
        @(negedge BIT_CLK) RESET = 1'b1;
        repeat (3) step(1'b0, 1'b0, -1);

        // Back-to-back write frames
        clr();
        repeat (3) drive_frame(FR_A, 16, 256);
        chk("norm_fv", 256'(fv_cnt), 256'd2);
        chk("norm_err", 256'(err_cnt), 256'd0);
        chk("norm_load", 256'(load_cnt), 256'd3);
        chk("norm_cmd_cnt", 256'(cmd_cnt), 256'd2);
        chk("norm_cmd", 256'({c_wr, c_addr, c_data}), 256'({1'b1, 7'h02, 16'h1234}));
        chk("norm_frame_out", last_fo, FR_A);
        chk("tx_serial", cap, FRAME_IN);

        // SYNC dropped after 8 edges
        clr();
        drive_frame(FR_A, 8, 256);
        chk("drop_err", 256'(err_cnt), 256'd1);
        chk("drop_err_edge", 256'(err_idx), 256'd8);
        drive_frame(FR_A, 16, 100);
        chk("drop_fv", 256'(fv_cnt), 256'd2);
        chk("drop_err_total", 256'(err_cnt), 256'd1);
        chk("drop_frame_out", last_fo, FR_A);

        // SYNC re-rises at S+100: partial frame discarded, realign there
        drive_frame(FR_B, 16, 256);
        chk("rise_err", 256'(err_cnt), 256'd2);
        chk("rise_err_edge", 256'(err_idx), 256'd0);
        chk("rise_no_fv", 256'(fv_cnt), 256'd2);
        drive_frame(FR_B, 16, 50);
        chk("realign_fv", 256'(fv_cnt), 256'd3);
        chk("realign_frame", last_fo, FR_B);

        // Reset at S+50 for 3 cycles
        @(negedge BIT_CLK);
        RESET = 1'b0; SYNC = 1'b0;
        #1;
        chk("mid_rst_frame_out", FRAME_OUT, 256'h0);
        chk("mid_rst_outs", 256'({SDATA_IN, FRAME_VALID, FRAME_LOAD, SYNC_ERR}), 256'h0);
        repeat (3) @(posedge BIT_CLK);
        @(negedge BIT_CLK) RESET = 1'b1;
        clr();
        drive_frame(FR_B, 16, 256);
        chk("post_rst_no_fv", 256'(fv_cnt), 256'd0);
        drive_frame(FR_A, 16, 256);
        chk("post_rst_fv", 256'(fv_cnt), 256'd1);
        chk("post_rst_frame", last_fo, FR_B);
        chk("post_rst_err", 256'(err_cnt), 256'd0);

        // Write 0x02=BEEF, read 0x02, observe the following TX frame
        drive_frame(FR_W, 16, 256);
        drive_frame(FR_RD, 16, 256);
        chk("wr_cmd", 256'({c_wr, c_addr, c_data}), 256'({1'b1, 7'h02, 16'hBEEF}));
        drive_frame(FR_B, 16, 256);
        chk("rd_cmd", 256'({c_wr, c_addr, c_data}), 256'({1'b0, 7'h02, 16'h0000}));
        exp_tx = FRAME_IN;
`ifdef AC97_CODEC_REGFILE_EN
        exp_tx[254] = 1'b1;
        exp_tx[253] = 1'b1;
        exp_tx[239:220] = 20'h02000;
        exp_tx[219:200] = 20'hBEEF0;
`endif
        chk("rd_tx_frame", cap, exp_tx);
        drive_frame(FR_B, 16, 1);
        chk("final_frame", last_fo, FR_B);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
